// File: rtl/pixel_scan_if.sv
// Pixel scan counter bus: increment/clear controls from the pixel input
// stage, plus raster coordinates and position flags returned to it.
//   increment_i, clear_i                 : controls into the counter
//   col_o, row_o                         : registered raster position
//   line_last_o, frame_last_o, border_o  : combinational position flags
//   frame_end_o, done_o                  : registered frame status
interface pixel_scan_if #(
    parameter int CW = 4,
    parameter int RW = 4
);
    logic          increment_i;
    logic          clear_i;
    logic [CW-1:0] col_o;
    logic [RW-1:0] row_o;
    logic          line_last_o;
    logic          frame_last_o;
    logic          border_o;
    logic          frame_end_o;
    logic          done_o;

    modport master (
        output increment_i, clear_i,
        input  col_o, row_o, line_last_o, frame_last_o, border_o,
               frame_end_o, done_o
    );

    modport slave (
        input  increment_i, clear_i,
        output col_o, row_o, line_last_o, frame_last_o, border_o,
               frame_end_o, done_o
    );
endinterface

// File: rtl/pixel_scan_counter.sv
// Raster-scan column/row generator for the median-filter datapath.
// Advances one pixel per accepted increment, wraps columns into rows and
// rows into frames, and flags line end, frame end and 3x3 border pixels.
//   CLK  : rising-edge clock
//   RST  : synchronous active-low reset
//   bus  : pixel_scan_if slave (controls in, coordinates/flags out)
module pixel_scan_counter #(
    parameter int IMG_W       = 8,
    parameter int IMG_H       = 8,
    parameter int CW          = 4,
    parameter int RW          = 4,
    parameter int STOP_AT_END = 0
) (
    input  logic         CLK,
    input  logic         RST,
    pixel_scan_if.slave  bus
);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic          STOP     = (STOP_AT_END != 0);

    logic [CW-1:0] col_q, col_n;
    logic [RW-1:0] row_q, row_n;
    logic          frame_end_q, frame_end_n;
    logic          done_q, done_n;
    logic          accept;
    logic          at_col_last;
    logic          at_row_last;

    assign at_col_last = (col_q == COL_LAST);
    assign at_row_last = (row_q == ROW_LAST);

    // In stop mode a finished frame freezes the counter until clear.
    assign accept = bus.increment_i && !(STOP && done_q);

    always_comb begin
        col_n       = col_q;
        row_n       = row_q;
        frame_end_n = 1'b0;
        done_n      = done_q;
        if (bus.clear_i) begin
            col_n  = '0;
            row_n  = '0;
            done_n = 1'b0;
        end else if (accept) begin
            // Wrap by compare-to-limit so non-power-of-2 sizes are exact.
            if (!at_col_last) begin
                col_n = col_q + 1'b1;
            end else if (!at_row_last) begin
                col_n = '0;
                row_n = row_q + 1'b1;
            end else begin
                col_n       = '0;
                row_n       = '0;
                frame_end_n = 1'b1;
                done_n      = STOP;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            col_q       <= '0;
            row_q       <= '0;
            frame_end_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            col_q       <= col_n;
            row_q       <= row_n;
            frame_end_q <= frame_end_n;
            done_q      <= done_n;
        end
    end

    assign bus.col_o        = col_q;
    assign bus.row_o        = row_q;
    assign bus.frame_end_o  = frame_end_q;
    assign bus.done_o       = done_q;
    assign bus.line_last_o  = at_col_last;
    assign bus.frame_last_o = at_col_last && at_row_last;
    assign bus.border_o     = (row_q == '0) || at_row_last ||
                              (col_q == '0) || at_col_last;
endmodule
